// File: rtl/fp_multiply_seq.sv
// Sequential IEEE-754-style multiplier: shift-add significand product, one multiplier
// bit per clock, round-to-nearest-even, flush-to-zero, start/busy/done handshake.
module fp_multiply_seq #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         busy,
  output logic         muldone,
  output logic [W-1:0] FPP,
  output logic [3:0]   flags
);
  localparam int N  = MAN_W + 1;
  localparam int CW = $clog2(N + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, PACK} state_t;
  state_t st, nxt;

  logic             sign_q, spec_q;
  logic [W-1:0]     spec_res_q;
  logic [3:0]       spec_flg_q;
  logic [EW-1:0]    e_q;
  logic [N-1:0]     mc_q, mr_q;
  logic [2*N-1:0]   prod_q;
  logic [CW-1:0]    cnt_q;
  logic [MAN_W-1:0] frac_q;
  logic             grd_q, stk_q;

  // operand classification (exponent field 0 is treated as zero)
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] fx, fy;
  logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, special, sgn;
  logic [W-1:0] spec_res;
  logic [3:0]   spec_flg;

  assign ex     = X[W-2:MAN_W];
  assign ey     = Y[W-2:MAN_W];
  assign fx     = X[MAN_W-1:0];
  assign fy     = Y[MAN_W-1:0];
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_inf  = (&ex) && (fx == '0);
  assign y_inf  = (&ey) && (fy == '0);
  assign x_nan  = (&ex) && (|fx);
  assign y_nan  = (&ey) && (|fy);
  assign sgn    = X[W-1] ^ Y[W-1];
  assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;

  always_comb begin
    spec_res = {sgn, {(W-1){1'b0}}};
    spec_flg = 4'b0000;
    if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero)) begin
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flg = 4'b1000;
    end else if (x_inf || y_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE: if (Start) nxt = special ? PACK : MUL;
      MUL:  if (cnt_q == CW'(1)) nxt = NORM;
      NORM: nxt = PACK;
      PACK: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (st != IDLE);

  // one partial-product step: carry-out lands in the top bit, product shifts right
  logic [N:0] psum;
  assign psum = {1'b0, prod_q[2*N-1:N]} + (mr_q[0] ? {1'b0, mc_q} : {(N+1){1'b0}});

  // rounding and range check, consumed in PACK
  logic             inc;
  logic [MAN_W:0]   rsum;
  logic [EW-1:0]    e_r;
  logic             ovf, unf;
  logic [W-1:0]     res;
  logic [3:0]       res_flg;

  assign inc  = grd_q & (stk_q | frac_q[0]);
  assign rsum = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
  assign e_r  = e_q + {{(EW-1){1'b0}}, rsum[MAN_W]};
  assign unf  = e_r[EW-1] || (e_r == '0);
  assign ovf  = !e_r[EW-1] && (e_r >= EMAX);

  always_comb begin
    res     = {sign_q, e_r[EXP_W-1:0], rsum[MAN_W-1:0]};
    res_flg = {3'b000, grd_q | stk_q};
    if (ovf) begin
      res     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flg = 4'b0101;
    end else if (unf) begin
      res     = {sign_q, {(W-1){1'b0}}};
      res_flg = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0; spec_q <= 1'b0; spec_res_q <= '0; spec_flg_q <= '0;
      e_q <= '0; mc_q <= '0; mr_q <= '0; prod_q <= '0; cnt_q <= '0;
      frac_q <= '0; grd_q <= 1'b0; stk_q <= 1'b0;
      muldone <= 1'b0; FPP <= '0; flags <= '0;
    end else begin
      muldone <= 1'b0;
      case (st)
        IDLE: if (Start) begin
          sign_q     <= sgn;
          spec_q     <= special;
          spec_res_q <= spec_res;
          spec_flg_q <= spec_flg;
          e_q        <= {2'b00, ex} + {2'b00, ey} - BIAS;
          mc_q       <= {1'b1, fx};
          mr_q       <= {1'b1, fy};
          prod_q     <= '0;
          cnt_q      <= CW'(N);
        end
        MUL: begin
          prod_q <= {psum, prod_q[N-1:1]};
          mr_q   <= mr_q >> 1;
          cnt_q  <= cnt_q - CW'(1);
        end
        NORM: begin
          if (prod_q[2*N-1]) begin
            e_q    <= e_q + {{(EW-1){1'b0}}, 1'b1};
            frac_q <= prod_q[2*N-2:N];
            grd_q  <= prod_q[N-1];
            stk_q  <= |prod_q[N-2:0];
          end else begin
            frac_q <= prod_q[2*N-3:N-1];
            grd_q  <= prod_q[N-2];
            stk_q  <= |prod_q[N-3:0];
          end
        end
        PACK: begin
          muldone <= 1'b1;
          FPP     <= spec_q ? spec_res_q : res;
          flags   <= spec_q ? spec_flg_q : res_flg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_multiply_seq.sv
// Directed bench for fp_multiply_seq: single precision plus a half-precision instance.
module tb_fp_multiply_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, busy, muldone;
  logic [31:0] x, y, fpp;
  logic [3:0]  flags;
  logic        sh, bh, mdh;
  logic [15:0] xh, yh, fph;
  logic [3:0]  flh;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_multiply_seq u_sp (
    .clk(clk), .reset(reset), .Start(start), .X(x), .Y(y),
    .busy(busy), .muldone(muldone), .FPP(fpp), .flags(flags));

  fp_multiply_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .reset(reset), .Start(sh), .X(xh), .Y(yh),
    .busy(bh), .muldone(mdh), .FPP(fph), .flags(flh));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk); x = a; y = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (muldone) begin lat = i; break; end
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] efpp, input logic [3:0] eflg, input int elat);
    int lat;
    run_op(a, b, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_fpp"}, fpp, efpp);
    chk({tag, "_flg"}, {28'd0, flags}, {28'd0, eflg});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, muldone}, 32'd0);
  endtask

  task automatic check_h(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] efpp, input logic [3:0] eflg, input int elat);
    int lat;
    @(negedge clk); xh = a; yh = b; sh = 1'b1;
    @(posedge clk); #1 sh = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mdh) begin lat = i; break; end
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_fpp"}, {16'd0, fph}, {16'd0, efpp});
    chk({tag, "_flg"}, {28'd0, flh}, {28'd0, eflg});
  endtask

  initial begin
    int nd, lat, lat2;
    reset = 1'b1; start = 1'b0; x = '0; y = '0;
    sh = 1'b0; xh = '0; yh = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fpp", fpp, 32'h0);
    chk("rst_flg", {28'd0, flags}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, muldone}, 32'h0);
    @(negedge clk) reset = 1'b0;

    check_op("basic",  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    check_op("neg",    32'h40400000, 32'hBF000000, 32'hBFC00000, 4'b0000, 26);
    check_op("rne1",   32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26);
    check_op("rne2",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 26);
    check_op("tie_dn", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 26);
    check_op("tie_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26);
    check_op("ovf",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26);
    check_op("unf",    32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 26);
    check_op("zinf",   32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1);
    check_op("ninf",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    check_op("nan",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);

    // Start re-pulsed while busy must be dropped
    @(negedge clk); x = 32'h3FC00000; y = 32'h40000000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0; lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin x = 32'h0; y = 32'h7F800000; start = 1'b1; end
      if (i == 7) start = 1'b0;
      if (muldone) begin nd++; if (lat < 0) lat = i; end
    end
    chk("ign_cnt", nd, 1);
    chk("ign_lat", lat, 26);
    chk("ign_fpp", fpp, 32'h40400000);

    // Start held through muldone: second op accepted right after
    @(negedge clk); x = 32'h3F800001; y = 32'h3F800001; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (muldone) begin lat = i; break; end
    end
    chk("held_lat1", lat, 26);
    chk("held_fpp1", fpp, 32'h3F800002);
    x = 32'h40400000; y = 32'hBF000000;
    @(posedge clk); #1 start = 1'b0;
    lat2 = -1;
    for (int i = 2; i <= 61; i++) begin
      @(posedge clk); #1;
      if (muldone) begin lat2 = i; break; end
    end
    chk("held_gap", lat2, 27);
    chk("held_fpp2", fpp, 32'hBFC00000);

    // reset in the middle of an op aborts it silently
    @(negedge clk); x = 32'h3FC00000; y = 32'h40000000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_fpp", fpp, 32'h0);
    chk("abort_flg", {28'd0, flags}, 32'h0);
    @(negedge clk) reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (muldone) nd++;
    end
    chk("abort_nodone", nd, 0);
    check_op("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);

    check_h("half",     16'h3E00, 16'h4000, 16'h4200, 4'b0000, 13);
    check_h("half_ovf", 16'h7800, 16'h7800, 16'h7C00, 4'b0101, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
